// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the host-side robot command link.
package remote_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TX_HI     = 2'd1,
    TX_LO     = 2'd2,
    WAIT_RESP = 2'd3
  } link_state_t;

  localparam logic [7:0] RESP_DONE  = 8'hA5;
  localparam logic [7:0] RESP_PROG  = 8'h5A;
  localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/link_uart.sv
// Byte-level 8N1 UART: registered transmitter plus free-running receiver.
module link_uart
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic          tx_act_q;
  logic [BW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;
  logic          tx_q;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_act_q;
  logic [BW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_rdy_q;

  // A new trmt on the last stop-bit cycle reloads directly, so bytes chain with no gap.
  assign tx_done = tx_act_q && (tx_baud_q == '0) && (tx_bit_q == 4'd0);
  assign TX      = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_act_q   <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
    end else if (trmt) begin
      tx_act_q   <= 1'b1;
      tx_baud_q  <= BAUD_LAST;
      tx_bit_q   <= LAST_BIT;
      tx_shift_q <= {1'b1, tx_data};
      tx_q       <= 1'b0;
    end else if (tx_act_q) begin
      if (tx_baud_q != '0) begin
        tx_baud_q <= tx_baud_q - 1'b1;
      end else if (tx_bit_q == 4'd0) begin
        tx_act_q <= 1'b0;
      end else begin
        tx_q       <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bit_q   <= tx_bit_q - 1'b1;
        tx_baud_q  <= BAUD_LAST;
      end
    end
  end

  // rx_bit_q: 0 = start, 1..8 = data, LAST_BIT = stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_rdy_q  <= 1'b0;
      if (!rx_act_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_act_q  <= 1'b1;
          rx_baud_q <= BAUD_HALF;
          rx_bit_q  <= 4'd0;
        end
      end else if (rx_baud_q != '0) begin
        rx_baud_q <= rx_baud_q - 1'b1;
      end else begin
        rx_baud_q <= BAUD_LAST;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q) rx_act_q <= 1'b0;
          else           rx_bit_q <= 4'd1;
        end else if (rx_bit_q == LAST_BIT) begin
          rx_act_q <= 1'b0;
          if (rx_sync_q) begin
            rx_data_q <= rx_shift_q;
            rx_rdy_q  <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
        end
      end
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;

endmodule

// File: rtl/remote_cmd_link.sv
// Command link top: sends a 16-bit command as two UART bytes, then waits
// for the robot's one-byte response or a timeout.
module remote_cmd_link
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV     = 5208,
  parameter int RESP_TIMEOUT = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        resp_done,
  output logic        timeout
);

  localparam int            TW       = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

  link_state_t   state_q, state_d;
  logic [7:0]    cmd_lo_q;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          cmd_snt_q, cmd_snt_d;
  logic          timeout_q, timeout_d;
  logic          tmo_hit;
  logic          trmt, tx_done, rx_rdy;
  logic [7:0]    tx_data, rx_data;

  link_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy)
  );

  assign tmo_hit = (RESP_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_lo_q  <= 8'h00;
      tmo_cnt_q <= '0;
      cmd_snt_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      cmd_snt_q <= cmd_snt_d;
      timeout_q <= timeout_d;
      if (state_q == IDLE && snd_cmd) cmd_lo_q <= cmd[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (snd_cmd) state_d = TX_HI;
      TX_HI:     if (tx_done) state_d = TX_LO;
      TX_LO:     if (tx_done) state_d = WAIT_RESP;
      WAIT_RESP: if (rx_rdy || tmo_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter is held at zero outside WAIT_RESP, so it starts clean on entry and saturates at expiry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != WAIT_RESP)                 tmo_cnt_d = '0;
    else if (RESP_TIMEOUT != 0 && !tmo_hit)   tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_comb begin
    trmt      = 1'b0;
    tx_data   = cmd_lo_q;
    cmd_snt_d = 1'b0;
    timeout_d = 1'b0;
    resp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        trmt    = snd_cmd;
        tx_data = cmd[15:8];
      end
      TX_HI:     trmt = tx_done;
      TX_LO:     cmd_snt_d = tx_done;
      WAIT_RESP: begin
        resp_done = rx_rdy && (rx_data == RESP_DONE);
        timeout_d = !rx_rdy && tmo_hit;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign cmd_snt  = cmd_snt_q;
  assign timeout  = timeout_q;
  assign resp     = rx_data;
  assign resp_rdy = rx_rdy;

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench for remote_cmd_link with a bit-level UART model on TX and RX.
module tb_remote_cmd_link;
  import remote_cmd_pkg::*;

  localparam int BD = 16;
  localparam int RT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        RX = 1'b1;
  logic        TX, busy, cmd_snt, resp_rdy, resp_done, timeout;
  logic [7:0]  resp;

  int n_chk  = 0;
  int n_pass = 0;

  remote_cmd_link #(.BAUD_DIV(BD), .RESP_TIMEOUT(RT)) dut (
    .clk       (clk),
    .rst       (rst),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .TX        (TX),
    .RX        (RX),
    .busy      (busy),
    .cmd_snt   (cmd_snt),
    .resp      (resp),
    .resp_rdy  (resp_rdy),
    .resp_done (resp_done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic uart_rx_byte(output logic [7:0] b, output logic ok);
    int n = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (TX !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (TX !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (BD / 2) @(negedge clk);
    if (TX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BD) @(negedge clk);
    if (TX !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [15:0] c, output int cyc, output logic busy_held);
    cmd     = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd   = 1'b0;
    cmd       = ~c;
    busy_held = (busy === 1'b1);
    cyc       = 0;
    while (cmd_snt !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_held = 1'b0;
    end
  endtask

  task automatic wait_rdy(output logic got, output logic [7:0] r, output logic done,
                          output logic b_at, output logic b_after);
    int n = 0;
    got = 1'b0; r = 8'h00; done = 1'b0; b_at = 1'b0; b_after = 1'b0;
    while (resp_rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (resp_rdy !== 1'b1) return;
    got  = 1'b1;
    r    = resp;
    done = resp_done;
    b_at = busy;
    @(negedge clk);
    b_after = busy;
  endtask

  initial begin
    int         cyc, n, rdy_cnt;
    logic       bh, ok_hi, ok_lo, got, done, b_at, b_after, tx_hi;
    logic [7:0] b_hi, b_lo, r;

    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_snt", cmd_snt, 1'b0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_resp_done", resp_done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // basic command 0x2104
    fork
      do_cmd(16'h2104, cyc, bh);
      begin
        uart_rx_byte(b_hi, ok_hi);
        uart_rx_byte(b_lo, ok_lo);
      end
    join
    chk("c1_hi_byte", b_hi, 8'h21);
    chk("c1_lo_byte", b_lo, 8'h04);
    chk("c1_framing", {ok_hi, ok_lo}, 2'b11);
    chk("c1_cmd_snt_latency", cyc, 320);
    chk("c1_busy_held", bh, 1'b1);
    @(negedge clk);
    chk("c1_cmd_snt_one_cycle", cmd_snt, 1'b0);
    chk("c1_busy_waiting", busy, 1'b1);

    // done response
    fork
      rx_send(RESP_DONE, 1'b1);
      wait_rdy(got, r, done, b_at, b_after);
    join
    chk("done_got_rdy", got, 1'b1);
    chk("done_resp", r, 8'hA5);
    chk("done_resp_done", done, 1'b1);
    chk("done_busy_at_rdy", b_at, 1'b1);
    chk("done_busy_after", b_after, 1'b0);

    // in-progress response
    do_cmd(16'h1234, cyc, bh);
    chk("c2_cmd_snt_latency", cyc, 320);
    fork
      rx_send(RESP_PROG, 1'b1);
      wait_rdy(got, r, done, b_at, b_after);
    join
    chk("prog_got_rdy", got, 1'b1);
    chk("prog_resp", r, 8'h5A);
    chk("prog_resp_done", done, 1'b0);
    chk("prog_idle_after", b_after, 1'b0);

    // timeout with an ignored request while busy
    do_cmd(16'hBEEF, cyc, bh);
    chk("c3_cmd_snt_latency", cyc, 320);
    n = 0;
    tx_hi = 1'b1;
    while (timeout !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 100) begin
        cmd     = 16'h0000;
        snd_cmd = 1'b1;
      end
      if (n == 101) snd_cmd = 1'b0;
      if (TX !== 1'b1) tx_hi = 1'b0;
    end
    chk("tmo_latency", n, 2000);
    chk("tmo_busy", busy, 1'b0);
    @(negedge clk);
    chk("tmo_one_cycle", timeout, 1'b0);
    repeat (200) begin
      @(negedge clk);
      if (TX !== 1'b1) tx_hi = 1'b0;
    end
    chk("tmo_no_second_frame", tx_hi, 1'b1);
    chk("tmo_still_idle", busy, 1'b0);

    // framing error then a valid byte while idle
    rdy_cnt = 0;
    fork
      rx_send(8'h3C, 1'b0);
      repeat (200) begin
        @(negedge clk);
        if (resp_rdy === 1'b1) rdy_cnt++;
      end
    join
    chk("ferr_no_rdy", rdy_cnt, 0);
    chk("ferr_resp_kept", resp, 8'h5A);
    fork
      rx_send(RESP_DONE, 1'b1);
      wait_rdy(got, r, done, b_at, b_after);
    join
    chk("ferr_next_got_rdy", got, 1'b1);
    chk("ferr_next_resp", r, 8'hA5);
    chk("ferr_next_no_done_idle", done, 1'b0);

    // reset during bit 5 of the high byte
    cmd     = 16'h0F0F;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (99) @(negedge clk);
    chk("mid_tx_bit5_low", TX, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", TX, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pulses", {cmd_snt, resp_rdy, resp_done, timeout}, 4'b0000);
    chk("mid_rst_resp", resp, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      do_cmd(16'h0000, cyc, bh);
      begin
        uart_rx_byte(b_hi, ok_hi);
        uart_rx_byte(b_lo, ok_lo);
      end
    join
    chk("c4_hi_byte", b_hi, 8'h00);
    chk("c4_lo_byte", b_lo, 8'h00);
    chk("c4_framing", {ok_hi, ok_lo}, 2'b11);
    chk("c4_cmd_snt_latency", cyc, 320);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
